// File: rtl/simple_pkg.sv
// simple_pkg: constants and types shared by the SIMPLE core sequencer.
// Holds the phase indices, the opcode fields that change phase timing,
// and the phase controller state type.
package simple_pkg;

    localparam int NUM_PH = 5;
    localparam int WAIT_W = 3;

    // One-hot phase bit positions
    localparam int PH_IF = 0;
    localparam int PH_RD = 1;
    localparam int PH_EX = 2;
    localparam int PH_WB = 3;
    localparam int PH_PC = 4;

    // Opcode fields: instr[15:14] is the major opcode, instr[7:4] the ALU sub-op
    localparam logic [1:0] OP_LD   = 2'b00;
    localparam logic [1:0] OP_ST   = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b11;
    localparam logic [3:0] OP3_HLT = 4'b1111;

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } ctrl_state_t;

    // Loads and stores touch RAM in the exec/mem phase
    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic logic is_hlt_op(input logic [1:0] op, input logic [3:0] op3);
        return (op == OP_ALU) && (op3 == OP3_HLT);
    endfunction

endpackage

// File: rtl/phase_ctrl_if.sv
// phase_ctrl_if: control requests in, phase/load-enable/status out.
// master = the side issuing requests and the IR; slave = the sequencer.
interface phase_ctrl_if
    import simple_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic              run_req;
    logic              halt_req;
    logic              step_req;
    logic [15:0]       instr;
    logic [NUM_PH-1:0] phase;
    logic              ld_en;
    logic              halted;
    logic [CNT_W-1:0]  retired;

    modport master (
        output run_req, halt_req, step_req, instr,
        input  phase, ld_en, halted, retired
    );

    modport slave (
        input  run_req, halt_req, step_req, instr,
        output phase, ld_en, halted, retired
    );
endinterface

// File: rtl/wait_timer.sv
// wait_timer: loadable down-counter that stretches memory phases.
// Load has priority; otherwise it counts down and parks at zero.
module wait_timer
    import simple_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    output logic              zero
);
    logic [WAIT_W-1:0] cnt_reg;

    // Count down remaining wait states, reload on entry to a stretched phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);
endmodule

// File: rtl/phase_ctrl.sv
// phase_ctrl: five-phase instruction sequencer with run/halt/step control.
// Optional feature macro: PHASE_CTRL_STEP_EN enables the single-step state;
// without it step_req is accepted on the port but ignored.
module phase_ctrl
    import simple_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter bit BOOT_RUN = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    phase_ctrl_if.slave bus
);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_WAIT);
    // The reset P0 has no entry edge to load the timer, so it burns one
    // cycle loading MEM_WAIT-1 instead.
    localparam logic [WAIT_W-1:0] WAIT_BOOT = (MEM_WAIT > 0) ? WAIT_W'(MEM_WAIT - 1) : '0;
    localparam bit                BOOT_ARM  = BOOT_RUN && (MEM_WAIT > 0);

    ctrl_state_t        state_reg;
    logic [NUM_PH-1:0]  phase_reg;
    logic [NUM_PH-1:0]  phase_next;
    logic               halted_reg;
    logic               halt_pend_reg;
    logic               boot_arm_reg;
    logic [CNT_W-1:0]   retired_reg;

    logic               ld_en;
    logic               wait_zero;
    logic               wait_load;
    logic [WAIT_W-1:0]  wait_val;
    logic               step_in;
    logic               mem_op;
    logic               hlt_op;
    logic               boundary;
    logic               stop;
    logic               wake;
    logic               unused_bits;

`ifdef PHASE_CTRL_STEP_EN
    assign step_in     = bus.step_req;
    assign unused_bits = &{1'b0, bus.instr[13:8], bus.instr[3:0]};
`else
    assign step_in     = 1'b0;
    assign unused_bits = &{1'b0, bus.instr[13:8], bus.instr[3:0], bus.step_req};
`endif

    assign mem_op = is_mem_op(bus.instr[15:14]);
    assign hlt_op = is_hlt_op(bus.instr[15:14], bus.instr[7:4]);

    // A phase ends when no wait states remain; nothing advances while halted
    assign ld_en    = !rst && !halted_reg && wait_zero && !boot_arm_reg;
    assign boundary = phase_reg[PH_PC] && ld_en;
    // halt wins over run/step when they arrive together in HALTED
    assign wake     = halted_reg && !bus.halt_req && (bus.run_req || step_in);

`ifdef PHASE_CTRL_STEP_EN
    assign stop = hlt_op || halt_pend_reg || bus.halt_req || (state_reg == ST_STEP);
`else
    assign stop = hlt_op || halt_pend_reg || bus.halt_req;
`endif

    // Left rotation of the one-hot phase, P4 wraps to P0
    for (genvar gi = 0; gi < NUM_PH; gi++) begin : g_rot
        assign phase_next[gi] = phase_reg[(gi + NUM_PH - 1) % NUM_PH];
    end

    // Arm the wait timer on entry to every fetch and to exec/mem of LD/ST
    always_comb begin
        wait_load = 1'b0;
        wait_val  = WAIT_LOAD;
        if (boot_arm_reg) begin
            wait_load = 1'b1;
            wait_val  = WAIT_BOOT;
        end else if (wake) begin
            wait_load = 1'b1;
        end else if (ld_en && phase_reg[PH_RD] && mem_op) begin
            wait_load = 1'b1;
        end else if (boundary && !stop) begin
            wait_load = 1'b1;
        end
    end

    wait_timer u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (wait_load),
        .load_val (wait_val),
        .zero     (wait_zero)
    );

    // Run/halt/step state, phase rotation and retire count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= BOOT_RUN ? ST_RUN : ST_HALTED;
            halted_reg    <= !BOOT_RUN;
            phase_reg     <= NUM_PH'(1);
            halt_pend_reg <= 1'b0;
            boot_arm_reg  <= BOOT_ARM;
            retired_reg   <= '0;
        end else begin
            boot_arm_reg <= 1'b0;
            if (halted_reg) begin
                if (wake) begin
`ifdef PHASE_CTRL_STEP_EN
                    state_reg <= bus.run_req ? ST_RUN : ST_STEP;
`else
                    state_reg <= ST_RUN;
`endif
                    halted_reg <= 1'b0;
                end
            end else begin
                if (bus.halt_req) begin
                    halt_pend_reg <= 1'b1;
                end
                if (ld_en) begin
                    phase_reg <= phase_next;
                end
                if (boundary) begin
                    retired_reg <= retired_reg + CNT_W'(1);
                    if (stop) begin
                        state_reg     <= ST_HALTED;
                        halted_reg    <= 1'b1;
                        halt_pend_reg <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.phase   = phase_reg;
    assign bus.ld_en   = ld_en;
    assign bus.halted  = halted_reg;
    assign bus.retired = retired_reg;
endmodule

// File: tb/tb_phase_ctrl.sv
// tb_phase_ctrl: scoreboard bench for phase_ctrl.
// dut_a: MEM_WAIT=0, BOOT_RUN=1, 16-bit count. dut_b: MEM_WAIT=2,
// BOOT_RUN=0, 3-bit count (so the retire counter wraps quickly).
// Stimulus pushes the expected outputs for each cycle; one monitor per
// DUT pops and compares on the falling edge.
module tb_phase_ctrl;

    localparam logic [15:0] I_ADD = 16'hC012;
    localparam logic [15:0] I_LD  = 16'h0123;
    localparam logic [15:0] I_HLT = 16'hC0F0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    phase_ctrl_if #(.CNT_W(16)) bus_a ();
    phase_ctrl_if #(.CNT_W(3))  bus_b ();

    phase_ctrl #(.MEM_WAIT(0), .BOOT_RUN(1'b1), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    phase_ctrl #(.MEM_WAIT(2), .BOOT_RUN(1'b0), .CNT_W(3)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    typedef struct {
        logic [4:0]  ph;
        logic        ld;
        logic        hl;
        logic [15:0] ret;
        int          tag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   seq    = 0;

    // Monitor for dut_a
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            checks++;
            if (bus_a.phase !== e.ph || bus_a.ld_en !== e.ld ||
                bus_a.halted !== e.hl || bus_a.retired !== e.ret) begin
                errors++;
                $display("FAIL a#%0d got phase=%b ld_en=%b halted=%b retired=%0d want phase=%b ld_en=%b halted=%b retired=%0d",
                         e.tag, bus_a.phase, bus_a.ld_en, bus_a.halted, bus_a.retired, e.ph, e.ld, e.hl, e.ret);
            end else begin
                $display("ok   a#%0d phase=%b ld_en=%b halted=%b retired=%0d",
                         e.tag, bus_a.phase, bus_a.ld_en, bus_a.halted, bus_a.retired);
            end
        end
    end

    // Monitor for dut_b
    always @(negedge clk) begin
        exp_t e;
        if (qb.size() > 0) begin
            e = qb.pop_front();
            checks++;
            if (bus_b.phase !== e.ph || bus_b.ld_en !== e.ld ||
                bus_b.halted !== e.hl || 16'(bus_b.retired) !== e.ret) begin
                errors++;
                $display("FAIL b#%0d got phase=%b ld_en=%b halted=%b retired=%0d want phase=%b ld_en=%b halted=%b retired=%0d",
                         e.tag, bus_b.phase, bus_b.ld_en, bus_b.halted, bus_b.retired, e.ph, e.ld, e.hl, e.ret);
            end else begin
                $display("ok   b#%0d phase=%b ld_en=%b halted=%b retired=%0d",
                         e.tag, bus_b.phase, bus_b.ld_en, bus_b.halted, bus_b.retired);
            end
        end
    end

    function automatic logic [4:0] ph_of(input int i);
        logic [4:0] v;
        v = 5'b00001 << i;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit d, input logic rr, input logic hr, input logic sr,
                         input logic [15:0] ins);
        if (d == 1'b0) begin
            bus_a.run_req  = rr;
            bus_a.halt_req = hr;
            bus_a.step_req = sr;
            bus_a.instr    = ins;
        end else begin
            bus_b.run_req  = rr;
            bus_b.halt_req = hr;
            bus_b.step_req = sr;
            bus_b.instr    = ins;
        end
    endtask

    task automatic expect_out(input bit d, input logic [4:0] ph, input logic ld,
                              input logic hl, input int ret);
        exp_t e;
        e.ph  = ph;
        e.ld  = ld;
        e.hl  = hl;
        e.ret = 16'(ret);
        e.tag = seq;
        seq++;
        if (d == 1'b0) qa.push_back(e);
        else           qb.push_back(e);
    endtask

    // One clock cycle: inputs applied now are sampled at the next edge;
    // the expectation is for the outputs visible during this cycle.
    task automatic cyc(input bit d, input logic rr, input logic hr, input logic sr,
                       input logic [15:0] ins, input logic [4:0] ph, input logic ld,
                       input logic hl, input int ret);
        tick();
        drive(d, rr, hr, sr, ins);
        expect_out(d, ph, ld, hl, ret);
    endtask

    // One complete instruction on dut_b (MEM_WAIT=2): fetch is 3 cycles,
    // exec/mem is 3 cycles for LD/ST and 1 otherwise.
    task automatic instr_b(input logic [15:0] ins, input bit mem, input int ret);
        cyc(1'b1, 0, 0, 0, ins, 5'h01, 1'b0, 1'b0, ret);
        cyc(1'b1, 0, 0, 0, ins, 5'h01, 1'b0, 1'b0, ret);
        cyc(1'b1, 0, 0, 0, ins, 5'h01, 1'b1, 1'b0, ret);
        cyc(1'b1, 0, 0, 0, ins, 5'h02, 1'b1, 1'b0, ret);
        if (mem) begin
            cyc(1'b1, 0, 0, 0, ins, 5'h04, 1'b0, 1'b0, ret);
            cyc(1'b1, 0, 0, 0, ins, 5'h04, 1'b0, 1'b0, ret);
        end
        cyc(1'b1, 0, 0, 0, ins, 5'h04, 1'b1, 1'b0, ret);
        cyc(1'b1, 0, 0, 0, ins, 5'h08, 1'b1, 1'b0, ret);
        cyc(1'b1, 0, 0, 0, ins, 5'h10, 1'b1, 1'b0, ret);
    endtask

    initial begin
        int r0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(1'b0, 0, 0, 0, I_ADD);
        drive(1'b1, 0, 0, 0, I_LD);

        // Reset values while rst is held
        tick();
        expect_out(1'b0, 5'h01, 1'b0, 1'b0, 0);
        expect_out(1'b1, 5'h01, 1'b0, 1'b1, 0);

        // Release: dut_a boots straight into RUN, dut_b stays HALTED
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        expect_out(1'b0, 5'h01, 1'b1, 1'b0, 0);
        expect_out(1'b1, 5'h01, 1'b0, 1'b1, 0);

        // ADD stream, MEM_WAIT=0: 5-cycle instructions, ld_en always high
        for (int k = 1; k <= 10; k++)
            cyc(1'b0, 0, 0, 0, I_ADD, ph_of(k % 5), 1'b1, 1'b0, k / 5);

        // halt_req in P1: instruction completes, then HALTED
        cyc(1'b0, 0, 1, 0, I_ADD, 5'h02, 1'b1, 1'b0, 2);
        for (int k = 12; k <= 14; k++)
            cyc(1'b0, 0, 0, 0, I_ADD, ph_of(k % 5), 1'b1, 1'b0, 2);
        cyc(1'b0, 0, 0, 0, I_ADD, 5'h01, 1'b0, 1'b1, 3);

        // step_req from HALTED
        cyc(1'b0, 0, 0, 1, I_ADD, 5'h01, 1'b0, 1'b1, 3);
`ifdef PHASE_CTRL_STEP_EN
        for (int k = 0; k < 5; k++)
            cyc(1'b0, 0, 0, 0, I_ADD, ph_of(k), 1'b1, 1'b0, 3);
        r0 = 4;
`else
        for (int k = 0; k < 5; k++)
            cyc(1'b0, 0, 0, 0, I_ADD, 5'h01, 1'b0, 1'b1, 3);
        r0 = 3;
`endif

        // HLT instruction: runs to its boundary, counts as retired, halts
        cyc(1'b0, 1, 0, 0, I_HLT, 5'h01, 1'b0, 1'b1, r0);
        for (int k = 0; k < 5; k++)
            cyc(1'b0, 0, 0, 0, I_HLT, ph_of(k), 1'b1, 1'b0, r0);
        cyc(1'b0, 0, 0, 0, I_HLT, 5'h01, 1'b0, 1'b1, r0 + 1);
        cyc(1'b0, 1, 0, 0, I_HLT, 5'h01, 1'b0, 1'b1, r0 + 1);

        // Resume: P0 on the next cycle; run_req and step_req in RUN ignored
        cyc(1'b0, 0, 0, 0, I_ADD, 5'h01, 1'b1, 1'b0, r0 + 1);
        cyc(1'b0, 1, 0, 0, I_ADD, 5'h02, 1'b1, 1'b0, r0 + 1);
        cyc(1'b0, 0, 0, 1, I_ADD, 5'h04, 1'b1, 1'b0, r0 + 1);
        cyc(1'b0, 0, 0, 0, I_ADD, 5'h08, 1'b1, 1'b0, r0 + 1);
        cyc(1'b0, 0, 0, 0, I_ADD, 5'h10, 1'b1, 1'b0, r0 + 1);
        cyc(1'b0, 0, 0, 0, I_ADD, 5'h01, 1'b1, 1'b0, r0 + 2);

        // Halt again, then run_req+halt_req together: halt wins
        cyc(1'b0, 0, 1, 0, I_ADD, 5'h02, 1'b1, 1'b0, r0 + 2);
        cyc(1'b0, 0, 0, 0, I_ADD, 5'h04, 1'b1, 1'b0, r0 + 2);
        cyc(1'b0, 0, 0, 0, I_ADD, 5'h08, 1'b1, 1'b0, r0 + 2);
        cyc(1'b0, 0, 0, 0, I_ADD, 5'h10, 1'b1, 1'b0, r0 + 2);
        cyc(1'b0, 1, 1, 0, I_ADD, 5'h01, 1'b0, 1'b1, r0 + 3);
        cyc(1'b0, 0, 0, 0, I_ADD, 5'h01, 1'b0, 1'b1, r0 + 3);
        cyc(1'b0, 0, 0, 0, I_ADD, 5'h01, 1'b0, 1'b1, r0 + 3);

        // dut_b, MEM_WAIT=2: LD takes 9 cycles, ADD 7; 3-bit count wraps
        cyc(1'b1, 1, 0, 0, I_LD, 5'h01, 1'b0, 1'b1, 0);
        instr_b(I_LD, 1'b1, 0);
        for (int n = 1; n <= 9; n++)
            instr_b(I_ADD, 1'b0, n % 8);

        // Async reset in the middle of a stretched LD exec/mem phase
        cyc(1'b1, 0, 0, 0, I_LD, 5'h01, 1'b0, 1'b0, 2);
        cyc(1'b1, 0, 0, 0, I_LD, 5'h01, 1'b0, 1'b0, 2);
        cyc(1'b1, 0, 0, 0, I_LD, 5'h01, 1'b1, 1'b0, 2);
        cyc(1'b1, 0, 0, 0, I_LD, 5'h02, 1'b1, 1'b0, 2);
        cyc(1'b1, 0, 0, 0, I_LD, 5'h04, 1'b0, 1'b0, 2);
        tick();
        rst_b = 1'b1;
        expect_out(1'b1, 5'h01, 1'b0, 1'b1, 0);
        tick();
        expect_out(1'b1, 5'h01, 1'b0, 1'b1, 0);
        tick();
        rst_b = 1'b0;
        expect_out(1'b1, 5'h01, 1'b0, 1'b1, 0);

        // Restart after reset: full-length fetch and LD again
        cyc(1'b1, 1, 0, 0, I_LD, 5'h01, 1'b0, 1'b1, 0);
        instr_b(I_LD, 1'b1, 0);
        instr_b(I_ADD, 1'b0, 1);

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_ctrl.md
# phase_ctrl

Instruction-phase sequencer for the SIMPLE multi-cycle core. It drives the one-hot five-phase vector through fetch, register read, execute/memory, writeback and PC update. It stretches memory phases by a fixed number of RAM wait states and provides run, halt and single-step control at instruction boundaries. It supersedes the free-running phase counter and the HLT flip-flop, and sits between the instruction register and every phase-qualified load enable in the datapath.

## Interface
- MEM_WAIT, 0, extra cycles held in a memory phase (0..7)
- BOOT_RUN, 1, 1 = enter RUN after reset; 0 = enter HALTED
- CNT_W, 16, width of retired-instruction counter
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- run_req  in  1  pulse; leave HALTED and run continuously
- halt_req  in  1  pulse; stop at the next instruction boundary
- step_req  in  1  pulse; from HALTED, execute exactly one instruction
- instr  in  16  current IR contents; valid from P1 onward
- phase  out  5  one-hot: [0] fetch, [1] reg read, [2] exec/mem, [3] writeback, [4] PC update
- ld_en  out  1  high on the final cycle of the current phase; datapath loads are gated by phase & ld_en
- halted  out  1  core is stopped
- retired  out  CNT_W  count of completed instructions

## Operation
- States: HALTED, RUN, STEP.
- Reset: phase=5'b00001, ld_en=0, retired=0, halt_pend=0. State is RUN with halted=0 if BOOT_RUN, else HALTED with halted=1. Wait counter is cleared.
- HALTED: phase is held at 5'b00001, ld_en=0.
  - run_req → RUN.
  - step_req → STEP.
  - halt_req is ignored.
- Phase advance: phase rotates left one position when ld_en=1; P4 wraps to P0.
- Phase lengths:
  - P0 lasts 1+MEM_WAIT cycles.
  - P2 lasts 1+MEM_WAIT cycles when instr[15:14] is 2'b00 (LD) or 2'b01 (ST); otherwise 1 cycle.
  - P1, P3 and P4 last 1 cycle each.
- Wait counter: loaded with MEM_WAIT on entry to a stretched phase and decremented each cycle. ld_en=1 when the counter is 0.
- Instruction boundary: the cycle with P4 & ld_en. On this cycle retired increments, wrapping modulo 2^CNT_W; the HLT instruction counts as retired.
- Stop conditions, evaluated at the boundary:
  - HLT (instr[15:14]=2'b11 and instr[7:4]=4'b1111), or halt_pend, or state STEP → HALTED, halted=1, halt_pend cleared.
  - Otherwise continue in P0.
- halt_req in RUN or STEP sets the sticky halt_pend. Phases in flight always complete; there is no mid-instruction abort.
- Simultaneous requests:
  - run_req and halt_req in the same cycle from HALTED → halt wins; stay HALTED.
  - run_req in RUN → ignored.
  - step_req outside HALTED → ignored.
  - run_req and step_req together in HALTED → RUN.
- Resume after HLT: run_req continues at the PC already advanced past HLT.

## Timing
- Requests are sampled at a rising edge. The new state and the first P0 cycle take effect on the following cycle (1-cycle latency).
- With MEM_WAIT=0, one instruction takes 5 cycles.
- With wait states, LD and ST take 5+2·MEM_WAIT cycles; all other instructions take 5+MEM_WAIT.
- halted rises in the cycle after the boundary, the same cycle phase returns to 5'b00001.
- rst asserted at any point forces the reset values immediately, without a clock. Deassertion is synchronous to clk externally.
- All outputs are registered except ld_en, which is decoded from the registered phase and wait counter.

## Configuration
- PHASE_CTRL_STEP_EN defined: STEP state and step_req are implemented as described.
- PHASE_CTRL_STEP_EN undefined:
  - step_req is ignored and the STEP state is not built.
  - The port remains present, tied off internally.

## Structure
- Shared package simple_pkg holds:
  - phase index constants PH_IF, PH_RD, PH_EX, PH_WB, PH_PC
  - opcode field constants OP_LD=2'b00, OP_ST=2'b01, OP_ALU=2'b11, OP3_HLT=4'b1111
  - the controller state enum
- One sub-module, wait_timer: a loadable 3-bit down-counter with a zero flag, instantiated once.

## Test plan
- BOOT_RUN=1, MEM_WAIT=0, ADD instruction stream → phase sequence 01,02,04,08,10 repeats with ld_en constantly 1; retired increments every 5 cycles.
- MEM_WAIT=2, LD then ADD → LD takes 9 cycles (P0 and P2 each last 3 cycles), ADD takes 7 cycles; ld_en is high only on the last cycle of each phase.
- HLT (instr=16'hC0F0) → after its P4, halted=1, phase holds 5'b00001, retired includes the HLT; run_req resumes P0 on the next cycle.
- halt_req pulsed in P1 → instruction completes P2–P4, then HALTED; retired advances by exactly 1.
- From HALTED, step_req → exactly one instruction (5 cycles at MEM_WAIT=0), then halted=1. With the macro undefined → no phase change.
- rst asserted mid-P2 of a stretched LD → phase=5'b00001, retired=0, wait counter cleared asynchronously; BOOT_RUN=0 gives halted=1.
